// File: rtl/tx_data_buffer.sv
// Show-ahead byte FIFO between the host-side store path and the USB transmit encoder.
// Occupancy is tracked in its own register; full/empty never come from pointer compares.
module tx_data_buffer #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             store_tx_data,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             get_tx_packet_data,
  input  logic             flush,
  output logic [WIDTH-1:0] tx_packet_data,
  output logic [6:0]       buffer_occupancy,
  output logic             buffer_full,
  output logic             buffer_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PtrOne = AW'(1);
  localparam logic [6:0] OccMax = 7'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [6:0]    occ_q, occ_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic full, empty;
  logic pop_ok, push_ok;
  logic mem_we;

  assign full  = (occ_q == OccMax);
  assign empty = (occ_q == 7'd0);

  // A push into a full buffer is still accepted when a pop frees the head slot this cycle.
  assign pop_ok  = get_tx_packet_data & ~empty;
  assign push_ok = store_tx_data & (~full | pop_ok);

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    occ_d       = occ_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;

    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = 7'd0;
    end else begin
      overflow_d  = store_tx_data & ~push_ok;
      underflow_d = get_tx_packet_data & empty;

      if (push_ok) begin
        mem_we = 1'b1;
        wptr_d = wptr_q + PtrOne;
      end
      if (pop_ok) begin
        rptr_d = rptr_q + PtrOne;
      end

      unique case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + 7'd1;
        2'b01:   occ_d = occ_q - 7'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      occ_q       <= 7'd0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= tx_data;
    end
  end

  assign tx_packet_data   = empty ? '0 : mem_q[rptr_q];
  assign buffer_occupancy = occ_q;
  assign buffer_full      = full;
  assign buffer_empty     = empty;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

endmodule

// File: tb/tb_tx_data_buffer.sv
// Directed and randomized checks of tx_data_buffer against a queue-based reference model.
module tb_tx_data_buffer;

  localparam int DEPTH = 64;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       store_tx_data = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       get_tx_packet_data = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       buffer_full;
  logic       buffer_empty;
  logic       overflow;
  logic       underflow;

  tx_data_buffer #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .store_tx_data     (store_tx_data),
    .tx_data           (tx_data),
    .get_tx_packet_data(get_tx_packet_data),
    .flush             (flush),
    .tx_packet_data    (tx_packet_data),
    .buffer_occupancy  (buffer_occupancy),
    .buffer_full       (buffer_full),
    .buffer_empty      (buffer_empty),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: byte queue plus expected error pulses for the last edge.
  logic [7:0] q [$];
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (q.size() > 0) ? q[0] : 8'h00;
    check({tag, ".occ"},   32'(buffer_occupancy), 32'(q.size()));
    check({tag, ".full"},  32'(buffer_full),      32'(q.size() == DEPTH));
    check({tag, ".empty"}, 32'(buffer_empty),     32'(q.size() == 0));
    check({tag, ".head"},  32'(tx_packet_data),   32'(head));
    check({tag, ".ovf"},   32'(overflow),         32'(exp_ovf));
    check({tag, ".unf"},   32'(underflow),        32'(exp_unf));
  endtask

  // One clock: drive strobes, advance the model from the pre-edge state, sample #1 after the edge.
  task automatic cycle(input string tag, input logic push, input logic [7:0] d,
                       input logic pop, input logic fl);
    bit pop_ok, push_ok;
    store_tx_data      = push;
    tx_data            = d;
    get_tx_packet_data = pop;
    flush              = fl;
    if (fl) begin
      q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else begin
      pop_ok  = pop && (q.size() > 0);
      push_ok = push && ((q.size() < DEPTH) || pop_ok);
      exp_unf = pop && (q.size() == 0);
      exp_ovf = push && !push_ok;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(d);
    end
    @(posedge clk);
    #1;
    store_tx_data      = 1'b0;
    get_tx_packet_data = 1'b0;
    flush              = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // Reset state while held
    #12;
    check_all("reset");
    n_rst = 1'b0;

    // Reset mid-operation
    cycle("rst_push0", 1'b1, 8'hA5, 1'b0, 1'b0);
    cycle("rst_push1", 1'b1, 8'h3C, 1'b0, 1'b0);
    #3;
    n_rst = 1'b1;
    #1;
    q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    check_all("rst_async");
    check("rst_async.head0", 32'(tx_packet_data), 32'h0);
    #2;
    n_rst = 1'b0;
    cycle("rst_pop_unf", 1'b0, 8'h00, 1'b1, 1'b0);
    check("rst_pop_unf.pulse", 32'(underflow), 32'h1);
    cycle("rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill and drain in order, with one overflow
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill.full", 32'(buffer_full), 32'h1);
    cycle("fill_ovf", 1'b1, 8'hFF, 1'b0, 1'b0);
    check("fill_ovf.pulse", 32'(overflow), 32'h1);
    cycle("fill_ovf_clear", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain.data", 32'(tx_packet_data), 32'(i));
      cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Simultaneous push and pop at full
    for (int i = 0; i < DEPTH; i++) cycle("fill2", 1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle("full_both", 1'b1, 8'h77, 1'b1, 1'b0);
    check("full_both.occ", 32'(buffer_occupancy), 32'd64);
    for (int i = 0; i < DEPTH - 1; i++) cycle("full_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("full_both.head77", 32'(tx_packet_data), 32'h77);
    cycle("full_last", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push and pop at empty
    cycle("empty_both", 1'b1, 8'h5A, 1'b1, 1'b0);
    check("empty_both.head", 32'(tx_packet_data), 32'h5A);
    check("empty_both.unf", 32'(underflow), 32'h1);
    cycle("empty_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around across pointer 64
    for (int i = 0; i < 40; i++) cycle("wrap_a", 1'b1, 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle("wrap_pa", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cycle("wrap_b", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    check("wrap.occ40", 32'(buffer_occupancy), 32'd40);
    for (int i = 0; i < 40; i++) begin
      check("wrap.data", 32'(tx_packet_data), 32'(8'h80 + i));
      cycle("wrap_pb", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    // Flush priority over both strobes
    for (int i = 0; i < 10; i++) cycle("fl_fill", 1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle("flush_all", 1'b1, 8'hEE, 1'b1, 1'b1);
    check("flush_all.occ0", 32'(buffer_occupancy), 32'd0);
    cycle("flush_push", 1'b1, 8'h11, 1'b0, 1'b0);
    check("flush_push.head", 32'(tx_packet_data), 32'h11);

    // Randomized traffic with phases that bias toward full and toward empty
    for (int i = 0; i < 3000; i++) begin
      int pp, gp;
      unique case ((i / 250) % 4)
        0: begin pp = 90; gp = 30; end
        1: begin pp = 50; gp = 50; end
        2: begin pp = 20; gp = 85; end
        default: begin pp = 95; gp = 95; end
      endcase
      cycle("rand", 1'($urandom_range(99) < pp), 8'($urandom),
            1'($urandom_range(99) < gp), 1'($urandom_range(299) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_data_buffer.md
# tx_data_buffer

Byte-wide FIFO feeding the USB transmitter. The host-side interface stores outgoing payload bytes here, and the transmitter's encoder pops them one per `get_tx_packet_data` strobe. The buffer always presents the head byte on `tx_packet_data` (show-ahead) and reports a live fill count on `buffer_occupancy`. The transmitter uses that count for packet sizing and error detection. The buffer also supports a synchronous flush and flags misuse (overflow/underflow) without corrupting its state.

## Interface
- `DEPTH`, 64, number of byte entries; must be a power of two, 2..64.
- `WIDTH`, 8, data width in bits; the transmitter consumes 8.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `n_rst`  in  1  one clock; reset is asynchronous and active-high. Asserted = 1 despite the codebase port name.
- `store_tx_data`  in  1  push strobe from the host side; one byte per cycle high.
- `tx_data`  in  WIDTH  byte to push; sampled when `store_tx_data`=1.
- `get_tx_packet_data`  in  1  pop strobe from the transmitter; one byte per cycle high.
- `flush`  in  1  synchronous clear of all contents.
- `tx_packet_data`  out  WIDTH  head byte; 0 when empty.
- `buffer_occupancy`  out  7  bytes stored, 0..DEPTH.
- `buffer_full`  out  1  `buffer_occupancy`==DEPTH.
- `buffer_empty`  out  1  `buffer_occupancy`==0.
- `overflow`  out  1  one-cycle pulse: push attempted while full and not popped.
- `underflow`  out  1  one-cycle pulse: pop attempted while empty.

## Operation
- **Storage and pointers**
  - Storage is a DEPTH x WIDTH register array. Memory contents are not reset.
  - Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is a separate 7-bit register. Full and empty are derived from occupancy only, never from pointer equality.
- **Accepted push**: `store_tx_data`=1 and (not full, or a pop is accepted in the same cycle).
  - `tx_data` is written at `wptr`.
  - `wptr` is incremented.
- **Accepted pop**: `get_tx_packet_data`=1 and not empty at the start of the cycle.
  - `rptr` is incremented.
- **Occupancy update**
  - +1 for an accepted push alone.
  - −1 for an accepted pop alone.
  - Unchanged when both are accepted.
- **Simultaneous push and pop**
  - When full: both accepted; occupancy stays DEPTH; no overflow.
  - When empty: push accepted; pop rejected with an underflow pulse; occupancy becomes 1. There is no same-cycle pass-through.
- **Rejected operations**
  - Rejected push: data dropped, pointers and occupancy unchanged, `overflow`=1 next cycle.
  - Rejected pop: pointers unchanged, `underflow`=1 next cycle.
- **flush** has priority over push and pop in the same cycle.
  - Pointers and occupancy are zeroed; any strobes that cycle are ignored.
  - No error pulses are produced.
- **Head output**: `tx_packet_data` = mem[`rptr`] when occupancy>0, else 0. This is combinational from registered state.
- **Error pulses** are registered: high exactly one cycle after the offending edge, then low unless the offence repeats.

## Timing
- **Reset** (`n_rst`=1, asynchronous):
  - `wptr`=`rptr`=0 and occupancy=0, so `buffer_empty`=1.
  - `buffer_full`=0, `tx_packet_data`=0, `overflow`=0, `underflow`=0.
  - All held while asserted. Reset mid-packet discards contents immediately.
- **Push latency**: a byte pushed at edge N into an empty buffer appears on `tx_packet_data` and is counted in `buffer_occupancy` after edge N.
- **Pop latency**: a pop at edge N presents the next byte (or 0 if now empty) after edge N. The transmitter samples `tx_packet_data` in the same cycle it asserts `get_tx_packet_data`.
- **Throughput**: one push and one pop per cycle, sustained.
- **Wrap-around**: after DEPTH pushes, `wptr` returns to 0 with no bubble; likewise for `rptr`.
- **Counter width**: occupancy never exceeds DEPTH and never underflows below 0; it must not be allowed to wrap.

## Test plan
- **Reset mid-operation**: reset, push 0xA5 then 0x3C, assert `n_rst` mid-cycle -> occupancy 0, empty=1, `tx_packet_data`=0 immediately; a subsequent pop gives `underflow`=1 for one cycle.
- **Fill and drain in order**: push 0x00..0x3F (64 bytes) -> full=1, occupancy 64; a 65th push of 0xFF gives `overflow` for one cycle with occupancy still 64. Pop 64 -> data 0x00..0x3F in order, then empty=1 and `tx_packet_data`=0.
- **Simultaneous at full**: at full (64 entries), push 0x77 with a pop -> no overflow, occupancy 64, head advances. After 63 further pops the head is 0x77.
- **Simultaneous at empty**: when empty, push 0x5A with a pop -> `underflow`=1, occupancy 1, `tx_packet_data`=0x5A.
- **Wrap-around**: push 40, pop 40, push 40 -> occupancy 40; popping yields the second batch in order across the pointer wrap at 64.
- **Flush priority**: with occupancy 10, assert `flush`, `store_tx_data` and `get_tx_packet_data` together -> occupancy 0, no error pulses; the next push of 0x11 gives occupancy 1 with head 0x11.
